cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single Common Data Bus (CDB) among the functional units of the Tomasulo core.
//  Each FU presents a completed result (ROB tag + value) with a valid/ready handshake.
//  The arbiter grants at most one per cycle, round-robin, and registers the winner onto the CDB.
//  The CDB broadcast feeds the reservation stations, the ROB and the register-status table.
// PARAMETERS
//  NUM_REQ  4   number of requesting functional units (>=2)
//  TAG_W    5   ROB tag width (32-entry ROB)
//  DATA_W   32  result width
//  CNT_W    16  width of the saturating conflict counter
// PORTS
//  clk           in   1                 rising-edge clock
//  rst_n         in   1                 asynchronous active-low reset
//  flush         in   1                 pipeline flush (mispredict/exception)
//  cdb_hold      in   1                 ROB write port busy; blocks new grants
//  req_valid     in   NUM_REQ           FU i has a result pending
//  req_tag       in   NUM_REQ*TAG_W     FU i ROB tag, slice [i*TAG_W +: TAG_W]
//  req_data      in   NUM_REQ*DATA_W    FU i result, slice [i*DATA_W +: DATA_W]
//  req_ready     out  NUM_REQ           one-hot grant; transfer = valid & ready
//  cdb_valid     out  1                 CDB broadcast valid
//  cdb_tag       out  TAG_W             broadcast ROB tag
//  cdb_data      out  DATA_W            broadcast value
//  cdb_src       out  clog2(NUM_REQ)    index of the FU that won
//  conflict_cnt  out  CNT_W             cycles where >1 requester was valid and a grant occurred
// BEHAVIOUR
//  - Reset (async, rst_n=0): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, conflict_cnt=0, rr_ptr=0.
//    req_ready is combinational and is 0 while in reset. Reset applies at any time, mid-transfer included.
//  - Grant (combinational, same cycle): with grant_en = !flush & !cdb_hold & rst_n,
//    req_ready[i]=1 only for the first i with req_valid[i]=1, searching circularly from rr_ptr.
//    req_ready is at most one-hot and never asserted for an invalid requester.
//  - Transfer when req_valid[g] & req_ready[g]. Next edge: cdb_valid<=1, cdb_tag/cdb_data<=slice g,
//    cdb_src<=g. Latency is 1 cycle, and each transfer produces exactly one cycle of cdb_valid.
//  - No transfer: next edge cdb_valid<=0. cdb_tag/data/src keep their last values (don't-care when invalid).
//  - rr_ptr: after a grant to g, rr_ptr<=(g==NUM_REQ-1)?0:g+1. It is unchanged with no grant or while cdb_hold.
//  - flush: no grant in that cycle. Next edge cdb_valid<=0 and rr_ptr<=0.
//    A broadcast already on the CDB in the flush cycle is not retracted. conflict_cnt is not cleared.
//  - flush and cdb_hold together: flush wins (rr_ptr<=0).
//  - conflict_cnt increments by 1 when a grant occurs while popcount(req_valid)>1. It saturates at 2^CNT_W-1.
//  - Requesters hold valid/tag/data stable until granted. Correctness of the arbiter does not depend on this.
//    If valid drops before a grant, that requester is simply skipped.
//  - Fairness: a continuously valid requester is granted within NUM_REQ grant-enabled cycles.
// TESTING
//  1. Reset asserted mid-stream with all req_valid=1 -> outputs 0 immediately, req_ready=0;
//     after release the first grant goes to FU0.
//  2. Only req_valid[2]=1, tag=5, data=0xDEADBEEF -> req_ready=4'b0100 in the same cycle;
//     next cycle cdb_valid=1, tag=5, data=0xDEADBEEF, src=2; cdb_valid=0 the cycle after.
//  3. All 4 valid for 5 cycles -> grants 0,1,2,3,0 in successive cycles; conflict_cnt=5.
//  4. After a grant to FU2 (rr_ptr=3), req_valid=4'b1001 -> FU3 granted, then FU0.
//  5. cdb_hold=1 for 3 cycles with FU1 valid -> req_ready=0 and cdb_valid=0;
//     drop hold -> FU1 granted, rr_ptr unchanged by the hold.
//  6. flush with rr_ptr=2 and FU1 valid -> no grant, next cdb_valid=0, rr_ptr=0;
//     preset conflict_cnt=0xFFFF plus a conflict grant -> stays 0xFFFF.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single Common Data Bus.
//   Functional units offer a finished result (ROB tag + value) with valid/ready.
//   At most one unit is granted per cycle. The grant is combinational and the
//   winner is registered onto the CDB one cycle later.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         pipeline flush: no grant, rr_ptr returns to 0
//   cdb_hold      ROB write port busy: no grant, rr_ptr held
//   req_valid     per-FU result pending
//   req_tag       per-FU ROB tag, slice [i*TAG_W +: TAG_W]
//   req_data      per-FU result, slice [i*DATA_W +: DATA_W]
//   req_ready     one-hot grant (transfer = valid & ready)
//   cdb_valid     registered broadcast valid, one cycle per transfer
//   cdb_tag/data  registered broadcast payload
//   cdb_src       index of the winning FU
//   conflict_cnt  saturating count of grants made while >1 FU was valid

// Per-requester grant: lane IDX wins when it is valid and no valid requester
// sits between rr_ptr and IDX in circular order.
module cdb_arb_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX     = 0,
  parameter int PTR_W   = 2
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               grant
);
  always_comb begin
    logic blocked;
    logic reached;
    int   j;
    blocked = 1'b0;
    reached = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!reached) begin
        if (j == IDX)                        reached = 1'b1;
        else if (req_valid[j[PTR_W-1:0]])    blocked = 1'b1;
      end
    end
    grant = en & req_valid[IDX] & !blocked;
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       cdb_hold,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [PTR_W-1:0]           cdb_src,
  output logic [CNT_W-1:0]           conflict_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  src;
  } cdb_t;

  logic [PTR_W-1:0] rr_ptr;
  logic             grant_en;
  logic             xfer;
  logic             multi;
  cdb_t             win;

  // rst_n gates the grant so req_ready is low throughout reset.
  assign grant_en = !flush & !cdb_hold & rst_n;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    cdb_arb_lane #(.NUM_REQ(NUM_REQ), .IDX(i), .PTR_W(PTR_W)) u_lane (
      .en        (grant_en),
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (req_ready[i])
    );
  end

  // req_ready is one-hot, so an OR-free priority mux is enough to pick the winner.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win.tag  = req_tag[i*TAG_W +: TAG_W];
        win.data = req_data[i*DATA_W +: DATA_W];
        win.src  = PTR_W'(i);
      end
    end
  end

  assign xfer  = |(req_ready & req_valid);
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      cdb_src      <= '0;
      conflict_cnt <= '0;
      rr_ptr       <= '0;
    end else begin
      cdb_valid <= xfer;
      if (xfer) begin
        cdb_tag  <= win.tag;
        cdb_data <= win.data;
        cdb_src  <= win.src;
        if (multi && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
      // flush and hold both suppress xfer, so only flush needs explicit handling.
      if (flush)
        rr_ptr <= '0;
      else if (xfer)
        rr_ptr <= (win.src == PTR_W'(NUM_REQ-1)) ? '0 : win.src + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int PW = 2;

  logic          clk, rst_n, flush, cdb_hold;
  logic [N-1:0]  req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready, req_ready_s;
  logic          cdb_valid, cdb_valid_s;
  logic [TW-1:0] cdb_tag, cdb_tag_s;
  logic [DW-1:0] cdb_data, cdb_data_s;
  logic [PW-1:0] cdb_src, cdb_src_s;
  logic [15:0]   conflict_cnt;
  logic [3:0]    conflict_cnt_s;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cdb_hold(cdb_hold),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cdb_hold(cdb_hold),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready_s), .cdb_valid(cdb_valid_s), .cdb_tag(cdb_tag_s),
    .cdb_data(cdb_data_s), .cdb_src(cdb_src_s), .conflict_cnt(conflict_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [PW-1:0] src;
    logic [15:0]   cnt;
    logic [3:0]    cnt_s;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int            m_rr;
  logic          m_v;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [PW-1:0] m_src;
  logic [15:0]   m_cnt;
  logic [3:0]    m_cnts;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_v = 0; m_tag = '0; m_data = '0; m_src = '0; m_cnt = '0; m_cnts = '0;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: check the combinational grant mid-cycle, predict the next CDB
  // state, then compare the registered outputs just after the edge.
  task automatic cyc();
    logic [N-1:0] er;
    int g, j;
    exp_t e;
    @(negedge clk);
    er = '0; g = -1;
    if (rst_n && !flush && !cdb_hold)
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("req_ready_s", 64'(req_ready_s), 64'(er));
    if (!rst_n) model_reset();
    else begin
      m_v = (g >= 0);
      if (g >= 0) begin
        m_tag  = req_tag[g*TW +: TW];
        m_data = req_data[g*DW +: DW];
        m_src  = PW'(g);
        if ($countones(req_valid) > 1) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (m_cnts != 4'hF)    m_cnts = m_cnts + 4'd1;
        end
      end
      if (flush) m_rr = 0;
      else if (g >= 0) m_rr = (g + 1) % N;
    end
    e.v = m_v; e.tag = m_tag; e.data = m_data; e.src = m_src; e.cnt = m_cnt; e.cnt_s = m_cnts;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
    chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
    chk("cdb_data", 64'(cdb_data), 64'(e.data));
    chk("cdb_src", 64'(cdb_src), 64'(e.src));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
    chk("conflict_cnt_s", 64'(conflict_cnt_s), 64'(e.cnt_s));
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cdb_hold = 1'b0;
    req_valid = '0; req_tag = '0; req_data = '0;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, TW'(i + 10), 32'hA000_0000 + DW'(i));
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    cyc();
    rst_n = 1'b1;

    // 1: reset mid-stream with everyone valid
    req_valid = 4'b1111;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_tag", 64'(cdb_tag), 64'd0);
    chk("midrst_data", 64'(cdb_data), 64'd0);
    chk("midrst_src", 64'(cdb_src), 64'd0);
    chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_src0", 64'(cdb_src), 64'd0);

    // 2: single requester FU2
    set_req(2, 5'd5, 32'hDEADBEEF);
    req_valid = 4'b0100;
    #1;
    chk("t2_ready", 64'(req_ready), 64'b0100);
    cyc();
    chk("t2_data", 64'(cdb_data), 64'hDEADBEEF);
    req_valid = '0;
    cyc();
    chk("t2_drop", 64'(cdb_valid), 64'd0);

    // 3: all valid for 5 cycles from a fresh reset -> 0,1,2,3,0
    rst_pulse();
    req_valid = 4'b1111;
    repeat (5) cyc();
    chk("t3_cnt5", 64'(conflict_cnt), 64'd5);
    chk("t3_src0", 64'(cdb_src), 64'd0);

    // 4: grant FU2, then 1001 -> FU3 then FU0
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b1001;
    cyc();
    chk("t4_src3", 64'(cdb_src), 64'd3);
    cyc();
    chk("t4_src0", 64'(cdb_src), 64'd0);

    // 5: hold blocks grants, rr_ptr untouched
    cdb_hold = 1'b1; req_valid = 4'b0010;
    repeat (3) cyc();
    chk("t5_hold_valid", 64'(cdb_valid), 64'd0);
    cdb_hold = 1'b0;
    cyc();
    chk("t5_src1", 64'(cdb_src), 64'd1);

    // 6: flush with rr_ptr=2 resets pointer; then flush+hold together
    req_valid = 4'b0010;
    cyc();
    flush = 1'b1;
    cyc();
    chk("t6_flush_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0; req_valid = 4'b1110;
    cyc();
    chk("t6_rr0_src1", 64'(cdb_src), 64'd1);
    cyc();
    flush = 1'b1; cdb_hold = 1'b1;
    cyc();
    flush = 1'b0; cdb_hold = 1'b0;
    cyc();
    chk("t6_fh_src1", 64'(cdb_src), 64'd1);

    // saturation on the narrow counter copy
    req_valid = 4'b1111;
    repeat (20) cyc();
    chk("sat_cnt_s", 64'(conflict_cnt_s), 64'hF);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      req_valid = N'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      cdb_hold  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) set_req(i, TW'($urandom), $urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
